// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: button-selected RGB565 test patterns with 2-cycle sync-matched pipeline; LCD_PATTERN_BORDER_EN adds a white frame border
module lcd_pattern_gen #(
  parameter int H_ACTIVE        = 480,
  parameter int V_ACTIVE        = 272,
  parameter int DEBOUNCE_CYCLES = 90000
) (
  input  logic       VGA_CLK,
  input  logic       RESETn,
  input  logic       BTN_MODE,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  input  logic       DEN_IN,
  input  logic [9:0] XPOS_IN,
  input  logic [9:0] YPOS_IN,
  output logic       HSYNC_OUT,
  output logic       VSYNC_OUT,
  output logic       DEN_OUT,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B,
  output logic [1:0] MODE,
  output logic [7:0] FRAME_CNT
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          btn_s1, btn_s2, btn_lvl, db_hit, press, pending;
  logic [DW-1:0] db_cnt;
  logic          vs_valid, vs_prev, frame_start;
  logic          hs1, vs1, den1, vis1, scr1, border;
  logic [8:4]    x1;
  logic [8:3]    y1;
  logic [2:0]    bar1, bar_n;
  logic          vis_n, scr_n;
  logic [4:0]    r_n, b_n;
  logic [5:0]    g_n;
`ifdef LCD_PATTERN_BORDER_EN
  logic          brd1;
  assign border = brd1;
`else
  assign border = 1'b0;
`endif
  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge VGA_CLK or negedge RESETn)
    if (!RESETn) {btn_s2, btn_s1} <= 2'b11;
    else {btn_s2, btn_s1} <= {btn_s1, BTN_MODE};
  // a level is accepted only after it differs from the accepted level for DEBOUNCE_CYCLES cycles in a row
  assign db_hit = (btn_s2 != btn_lvl) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign press  = db_hit && !btn_s2;
  // debounce counter and accepted level
  always_ff @(posedge VGA_CLK or negedge RESETn)
    if (!RESETn) begin
      btn_lvl <= 1'b1;
      db_cnt  <= '0;
    end else begin
      db_cnt <= (btn_s2 == btn_lvl || db_hit) ? '0 : db_cnt + DW'(1);
      if (db_hit) btn_lvl <= btn_s2;
    end
  // vs_prev only reflects a real post-reset sample, so a VSYNC held low through reset is not an edge
  assign frame_start = vs_prev && !vs1;
  // frame counter, pending press and mode stepping at frame start
  always_ff @(posedge VGA_CLK or negedge RESETn)
    if (!RESETn) begin
      vs_valid  <= 1'b0;
      vs_prev   <= 1'b0;
      pending   <= 1'b0;
      MODE      <= '0;
      FRAME_CNT <= '0;
    end else begin
      vs_valid <= 1'b1;
      vs_prev  <= vs_valid && vs1;
      pending  <= (pending && !frame_start) || press;
      if (frame_start) begin
        FRAME_CNT <= FRAME_CNT + 8'd1;
        if (pending) MODE <= MODE + 2'd1;
      end
    end
  // bar index from a chain of boundary comparators
  always_comb begin
    bar_n = '0;
    for (int i = 1; i < 8; i++) bar_n = bar_n + 3'(XPOS_IN >= 10'(i * (H_ACTIVE / 8)));
  end
  assign vis_n = DEN_IN && (XPOS_IN < 10'(H_ACTIVE)) && (YPOS_IN < 10'(V_ACTIVE));
  assign scr_n = (((XPOS_IN + 10'(FRAME_CNT)) & 10'd32) != '0) ^ YPOS_IN[5];
  // stage 1: delayed timing plus pre-decoded pattern terms
  always_ff @(posedge VGA_CLK or negedge RESETn)
    if (!RESETn) begin
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      den1 <= 1'b0;
      vis1 <= 1'b0;
      scr1 <= 1'b0;
      bar1 <= '0;
      x1   <= '0;
      y1   <= '0;
`ifdef LCD_PATTERN_BORDER_EN
      brd1 <= 1'b0;
`endif
    end else begin
      hs1  <= HSYNC_IN;
      vs1  <= VSYNC_IN;
      den1 <= DEN_IN;
      vis1 <= vis_n;
      scr1 <= scr_n;
      bar1 <= bar_n;
      x1   <= XPOS_IN[8:4];
      y1   <= YPOS_IN[8:3];
`ifdef LCD_PATTERN_BORDER_EN
      brd1 <= DEN_IN && (XPOS_IN == '0 || XPOS_IN == 10'(H_ACTIVE - 1) ||
                         YPOS_IN == '0 || YPOS_IN == 10'(V_ACTIVE - 1));
`endif
    end
  // pattern colour for the currently applied mode
  always_comb begin
    r_n = MODE == 2'd0 ? {5{x1[5] ^ y1[5]}} : MODE == 2'd1 ? {5{~bar1[1]}} : MODE == 2'd2 ? x1[8:4] : {5{scr1}};
    g_n = MODE == 2'd0 ? {6{x1[6] ^ y1[6]}} : MODE == 2'd1 ? {6{~bar1[2]}} : MODE == 2'd2 ? y1[8:3] : {6{scr1}};
    b_n = MODE == 2'd0 ? {5{x1[7] ^ y1[7]}} : MODE == 2'd1 ? {5{~bar1[0]}} : MODE == 2'd2 ? FRAME_CNT[7:3] : {5{scr1}};
  end
  // stage 2: blanked colour and delay-matched syncs
  always_ff @(posedge VGA_CLK or negedge RESETn)
    if (!RESETn) begin
      HSYNC_OUT <= 1'b1;
      VSYNC_OUT <= 1'b1;
      DEN_OUT   <= 1'b0;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
    end else begin
      HSYNC_OUT <= hs1;
      VSYNC_OUT <= vs1;
      DEN_OUT   <= den1;
      LCD_R     <= vis1 ? (border ? 5'h1f : r_n) : 5'h0;
      LCD_G     <= vis1 ? (border ? 6'h3f : g_n) : 6'h0;
      LCD_B     <= vis1 ? (border ? 5'h1f : b_n) : 5'h0;
    end
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: model-checked bench for lcd_pattern_gen with a shortened debounce window
module tb_lcd_pattern_gen;
  localparam int DBC = 20;
`ifdef LCD_PATTERN_BORDER_EN
  localparam bit BRD = 1'b1;
`else
  localparam bit BRD = 1'b0;
`endif
  logic       VGA_CLK = 0, RESETn = 1, BTN_MODE = 1, HSYNC_IN = 1, VSYNC_IN = 1, DEN_IN = 0;
  logic [9:0] XPOS_IN = 0, YPOS_IN = 0;
  logic       HSYNC_OUT, VSYNC_OUT, DEN_OUT;
  logic [4:0] LCD_R, LCD_B;
  logic [5:0] LCD_G;
  logic [1:0] MODE;
  logic [7:0] FRAME_CNT;
  int tests = 0, fails = 0;
  int m_mode = 0, m_fc = 0;
  bit m_pend = 0, m_lvl = 1;
  int bar_r[8] = '{31, 31, 0, 0, 31, 31, 0, 0};
  int bar_g[8] = '{63, 63, 63, 63, 0, 0, 0, 0};
  int bar_b[8] = '{31, 0, 31, 0, 31, 0, 31, 0};
  typedef struct {bit hs, vs, den; int x, y, mode, fc;} ent_t;
  ent_t e1, e2, cur, ex, rst_ent;

  lcd_pattern_gen #(.DEBOUNCE_CYCLES(DBC)) dut (
    .VGA_CLK(VGA_CLK), .RESETn(RESETn), .BTN_MODE(BTN_MODE), .HSYNC_IN(HSYNC_IN),
    .VSYNC_IN(VSYNC_IN), .DEN_IN(DEN_IN), .XPOS_IN(XPOS_IN), .YPOS_IN(YPOS_IN),
    .HSYNC_OUT(HSYNC_OUT), .VSYNC_OUT(VSYNC_OUT), .DEN_OUT(DEN_OUT), .LCD_R(LCD_R),
    .LCD_G(LCD_G), .LCD_B(LCD_B), .MODE(MODE), .FRAME_CNT(FRAME_CNT));

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_rgb(input ent_t e);
    int r, g, b;
    bit on;
    if (!e.den || e.x >= 480 || e.y >= 272) return 0;
    case (e.mode)
      0: begin
        r = ((e.x / 32) % 2 != (e.y / 32) % 2) ? 31 : 0;
        g = ((e.x / 64) % 2 != (e.y / 64) % 2) ? 63 : 0;
        b = ((e.x / 128) % 2 != (e.y / 128) % 2) ? 31 : 0;
      end
      1: begin
        r = bar_r[e.x / 60];
        g = bar_g[e.x / 60];
        b = bar_b[e.x / 60];
      end
      2: begin
        r = (e.x / 16) % 32;
        g = (e.y / 8) % 64;
        b = e.fc / 8;
      end
      default: begin
        on = ((((e.x + e.fc) % 1024) / 32) % 2) != ((e.y / 32) % 2);
        r = on ? 31 : 0;
        g = on ? 63 : 0;
        b = on ? 31 : 0;
      end
    endcase
    if (BRD && (e.x == 0 || e.x == 479 || e.y == 0 || e.y == 271)) begin
      r = 31;
      g = 63;
      b = 31;
    end
    return r * 2048 + g * 32 + b;
  endfunction

  initial begin
    rst_ent.hs = 1; rst_ent.vs = 1; rst_ent.den = 0;
    rst_ent.x = 0; rst_ent.y = 0; rst_ent.mode = 0; rst_ent.fc = 0;
    e1 = rst_ent;
    e2 = rst_ent;
  end

  always @(negedge VGA_CLK) begin
    ex = RESETn ? e2 : rst_ent;
    chk("rgb", int'({LCD_R, LCD_G, LCD_B}), exp_rgb(ex));
    chk("sync", int'({HSYNC_OUT, VSYNC_OUT, DEN_OUT}), int'({ex.hs, ex.vs, ex.den}));
    cur = rst_ent;
    if (RESETn) begin
      cur.hs = HSYNC_IN; cur.vs = VSYNC_IN; cur.den = DEN_IN;
      cur.x = int'(XPOS_IN); cur.y = int'(YPOS_IN); cur.mode = m_mode; cur.fc = m_fc;
    end
    e2 = e1;
    e1 = cur;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge VGA_CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESETn = 0;
    BTN_MODE = 1;
    m_mode = 0; m_fc = 0; m_pend = 0; m_lvl = 1;
    #1;
    chk("rst_rgb", int'({LCD_R, LCD_G, LCD_B}), 0);
    chk("rst_sync", int'({HSYNC_OUT, VSYNC_OUT, DEN_OUT}), 3'b110);
    chk("rst_mode", MODE, 0);
    chk("rst_fc", FRAME_CNT, 0);
    cyc(3);
    RESETn = 1;
  endtask

  task automatic btn_hold(input bit v, input int n);
    BTN_MODE = v;
    cyc(n);
    if (v != m_lvl && n >= DBC) begin
      m_lvl = v;
      if (!v) m_pend = 1;
    end
  endtask

  task automatic frame();
    DEN_IN = 0;
    VSYNC_IN = 0;
    cyc(3);
    VSYNC_IN = 1;
    cyc(3);
    m_fc = (m_fc + 1) % 256;
    if (m_pend) begin
      m_mode = (m_mode + 1) % 4;
      m_pend = 0;
    end
    chk("mode_model", MODE, m_mode);
    chk("fc_model", FRAME_CNT, m_fc);
  endtask

  task automatic lit(input string nm, input int x, input int y, input bit den, input int er, input int eg, input int eb);
    XPOS_IN = 10'(x);
    YPOS_IN = 10'(y);
    DEN_IN = den;
    repeat (3) @(negedge VGA_CLK);
    chk({nm, "_r"}, LCD_R, er);
    chk({nm, "_g"}, LCD_G, eg);
    chk({nm, "_b"}, LCD_B, eb);
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic sweep(input int n);
    repeat (n) begin
      XPOS_IN = 10'($urandom_range(0, 520));
      YPOS_IN = 10'($urandom_range(0, 300));
      DEN_IN = $urandom_range(0, 3) != 0;
      HSYNC_IN = 1'($urandom_range(0, 1));
      cyc(1);
    end
    DEN_IN = 0;
    HSYNC_IN = 1;
    cyc(2);
  endtask

  task automatic press();
    btn_hold(0, DBC + 2);
    btn_hold(1, DBC + 2);
  endtask

  initial begin
    #1;
    do_reset();
    cyc(2);
    chk("init_mode", MODE, 0);
    chk("init_fc", FRAME_CNT, 0);
    lit("m0_x32", 32, 0, 1, 31, BRD ? 63 : 0, BRD ? 31 : 0);
    DEN_IN = 0;
    cyc(3);
    HSYNC_IN = 0;
    DEN_IN = 1;
    @(negedge VGA_CLK);
    @(posedge VGA_CLK);
    #1;
    HSYNC_IN = 1;
    DEN_IN = 0;
    @(negedge VGA_CLK);
    chk("hs_d1", HSYNC_OUT, 1);
    chk("den_d1", DEN_OUT, 0);
    @(negedge VGA_CLK);
    chk("hs_d2", HSYNC_OUT, 0);
    chk("den_d2", DEN_OUT, 1);
    @(negedge VGA_CLK);
    chk("hs_d3", HSYNC_OUT, 1);
    chk("den_d3", DEN_OUT, 0);
    @(posedge VGA_CLK);
    #1;
    lit("den0", 100, 50, 0, 0, 0, 0);
    lit("x480", 480, 50, 1, 0, 0, 0);
    lit("y272", 100, 272, 1, 0, 0, 0);
    sweep(150);
    btn_hold(0, DBC - 1);
    btn_hold(1, DBC + 5);
    chk("short_pre", MODE, 0);
    frame();
    chk("short_press", MODE, 0);
    chk("fc1", FRAME_CNT, 1);
    btn_hold(0, DBC);
    btn_hold(1, DBC + 5);
    chk("pend_not_early", MODE, 0);
    frame();
    chk("press_mode1", MODE, 1);
    lit("bar0", 0, 100, 1, 31, 63, 31);
    lit("bar59", 59, 100, 1, 31, 63, 31);
    lit("bar60", 60, 100, 1, 31, 63, 0);
    lit("bar419", 419, 100, 1, 0, 0, 31);
    lit("bar420", 420, 100, 1, 0, 0, 0);
    lit("bar479", 479, 100, 1, BRD ? 31 : 0, BRD ? 63 : 0, BRD ? 31 : 0);
    sweep(150);
    press();
    press();
    frame();
    chk("two_press", MODE, 2);
    frame();
    chk("second_dropped", MODE, 2);
    sweep(200);
    press();
    frame();
    chk("mode3", MODE, 3);
    repeat (27) frame();
    chk("fc32", FRAME_CNT, 32);
    lit("m3_fc32", 0, 0, 1, 31, 63, 31);
    sweep(200);
    repeat (224) frame();
    chk("fc_wrap", FRAME_CNT, 0);
    press();
    frame();
    chk("mode_wrap", MODE, 0);
    lit("m0_x0_y100", 0, 100, 1, 31, 63, BRD ? 31 : 0);
    sweep(200);
    press();
    lit("pre_rst", 40, 10, 1, 31, 0, 0);
    VSYNC_IN = 0;
    #2;
    do_reset();
    cyc(5);
    VSYNC_IN = 1;
    DEN_IN = 0;
    cyc(3);
    chk("no_fs_after_rst", FRAME_CNT, 0);
    frame();
    chk("fs_after_rst", FRAME_CNT, 1);
    chk("pend_cleared", MODE, 0);
    sweep(100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_pattern_gen.md
Name: lcd_pattern_gen

Overview:
Pixel-colour stage that sits directly downstream of lcd_driver on the Tang Nano 9K LCD path. It consumes the timing outputs (HSYNC, VSYNC, DEN, XPOS, YPOS) and produces registered RGB565 plus delay-matched syncs for the LCD pins. A debounced user button selects one of four test patterns; a mode change takes effect only at a frame boundary. A per-frame counter drives the animated patterns.

Parameters:
H_ACTIVE, 480, active pixels per line
V_ACTIVE, 272, active lines per frame
DEBOUNCE_CYCLES, 90000, stable-level cycles before a button edge is accepted (10 ms at 9 MHz)

Ports:
VGA_CLK  in  1  pixel clock (9 MHz)
RESETn  in  1  async active-low reset
BTN_MODE  in  1  raw user button, active-low, asynchronous
HSYNC_IN  in  1  from lcd_driver
VSYNC_IN  in  1  from lcd_driver, active-low
DEN_IN  in  1  from lcd_driver, high in active area
XPOS_IN  in  10  pixel column
YPOS_IN  in  10  pixel row
HSYNC_OUT  out  1  HSYNC_IN delayed 2 cycles
VSYNC_OUT  out  1  VSYNC_IN delayed 2 cycles
DEN_OUT  out  1  DEN_IN delayed 2 cycles
LCD_R  out  5  red
LCD_G  out  6  green
LCD_B  out  5  blue
MODE  out  2  current applied pattern mode
FRAME_CNT  out  8  frame counter

Behaviour:
- One clock, VGA_CLK; reset is asynchronous and active-low on RESETn. All flops clear on RESETn low.
- Reset values: HSYNC_OUT=1, VSYNC_OUT=1, DEN_OUT=0, LCD_R/G/B=0, MODE=0, FRAME_CNT=0, pending=0, debounce state=released.
- Pipeline: stage 1 registers XPOS/YPOS/DEN/syncs and the pattern-select terms; stage 2 registers the colour. Latency is exactly 2 cycles for colour and all three syncs. No stalls.
- Blanking: if delayed DEN=0, or delayed XPOS>=H_ACTIVE, or delayed YPOS>=V_ACTIVE, then RGB=0.
- Button: 2-flop synchroniser, then debounce counter. The counter resets on any change from the accepted level. At DEBOUNCE_CYCLES-1 the new level is accepted. Accepting a press (high->low) sets pending for one event per press. A release must also debounce before the next press counts.
- Frame start: falling edge of the synchronised VSYNC_IN (one-cycle strobe).
  - At frame start, FRAME_CNT increments and wraps 255->0.
  - If pending=1 at frame start, MODE increments (3->0 wrap) and pending clears.
  - A press accepted in the same cycle as frame start stays pending until the next frame.
  - Further presses while pending=1 are discarded: at most one mode step per frame.
- Patterns (x,y = delayed XPOS/YPOS):
  - Mode 0: checkerboard. R=x[5]^y[5] ? 31 : 0; G=x[6]^y[6] ? 63 : 0; B=x[7]^y[7] ? 31 : 0.
  - Mode 1: 8 vertical bars, each H_ACTIVE/8 wide, found by comparator chain (no divider). Colour order: white, yellow, cyan, green, magenta, red, blue, black.
  - Mode 2: gradient. R=x[8:4]; G=y[8:3]; B=FRAME_CNT[7:3].
  - Mode 3: scrolling checkerboard. Let s=(x+FRAME_CNT) truncated to 10 bits. Colour is white if s[5]^y[5], else black.
- Reset mid-frame: outputs blank immediately. Frame start is not detected until the first VSYNC falling edge after release.

Optional Feature:
LCD_PATTERN_BORDER_EN
- Defined: pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 (and DEN=1) are forced white (31,63,31) in every mode. Latency is unchanged.
- Undefined: no border logic; the pattern is shown unmodified.

Test Plan:
- Reset then DEN=1, XPOS=32, YPOS=0, mode 0 -> 2 cycles later R=31, G=0, B=0; HSYNC_OUT/VSYNC_OUT/DEN_OUT equal inputs delayed by exactly 2 cycles.
- DEN_IN=0 with XPOS=100 in any mode -> RGB=0; XPOS=480 with DEN=1 -> RGB=0.
- BTN_MODE low for 89999 cycles, then high -> MODE stays 0. Low for 90000 cycles -> MODE becomes 1 only after the next VSYNC falling edge, not before.
- Two debounced presses within one frame -> MODE advances by 1 at frame start. The second press is dropped and MODE stays 1 after the following frame.
- Mode 1 at XPOS 0, 59, 60, 419, 420, 479 -> white, white, yellow, blue, black, black.
- 256 VSYNC falling edges -> FRAME_CNT returns to 0. In mode 3 with FRAME_CNT=32 and XPOS=0, YPOS=0 -> white. With LCD_PATTERN_BORDER_EN defined, mode 0 at XPOS=0, YPOS=100 -> (31,63,31).
